// File: rtl/game_flow_controller_pkg.sv
// Shared phase encodings, default timing constants and block geometry
// for the game flow controller slice.
package game_flow_controller_pkg;

  // Phase encodings exported on PHASE for the HUD and renderer
  typedef enum logic [2:0] {
    PH_ATTRACT     = 3'd0,
    PH_SERVE       = 3'd1,
    PH_PLAY        = 3'd2,
    PH_PAUSED      = 3'd3,
    PH_LIFE_LOST   = 3'd4,
    PH_LEVEL_CLEAR = 3'd5,
    PH_GAME_OVER   = 3'd6
  } phaseE;

  localparam int unsigned DEFAULT_INITIAL_LIVES      = 32'd3;
  localparam int unsigned DEFAULT_MAX_LEVEL          = 32'd7;
  localparam int unsigned DEFAULT_LOST_DELAY_FRAMES  = 32'd90;
  localparam int unsigned DEFAULT_CLEAR_DELAY_FRAMES = 32'd120;

  // Must agree with the game geometry include used by the game logic
  localparam int unsigned BLOCK_COUNT = 32'd72;

  // Phases in which the game logic receives its per-frame update
  function automatic logic isUpdatePhase(input phaseE ph);
    return (ph == PH_SERVE) || (ph == PH_PLAY);
  endfunction

endpackage

// File: rtl/game_flow_controller_btn_edge_detect.sv
// One-bit rising-edge detector: remembers last cycle's level so a held
// button produces a single-cycle EDGE.
module btn_edge_detect
  import game_flow_controller_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic EDGE
);

  logic btnPrevR;

  // Capture previous button level
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btnPrevR <= 1'b0;
    end else begin
      btnPrevR <= BTN;
    end
  end

  assign EDGE = BTN & ~btnPrevR;

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: gates the per-frame update trigger to rally phases,
// tracks lives/level and walks the serve/play/pause/lost/clear/over flow.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int unsigned INITIAL_LIVES      = DEFAULT_INITIAL_LIVES,
  parameter int unsigned MAX_LEVEL          = DEFAULT_MAX_LEVEL,
  parameter int unsigned LOST_DELAY_FRAMES  = DEFAULT_LOST_DELAY_FRAMES,
  parameter int unsigned CLEAR_DELAY_FRAMES = DEFAULT_CLEAR_DELAY_FRAMES,
  parameter int unsigned BLOCK_COUNT        = game_flow_controller_pkg::BLOCK_COUNT
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FRAME_START,
  input  logic                   UPDATE_BUSY,
  input  logic                   BTN_RELEASE,
  input  logic                   BTN_PAUSE,
  input  logic                   BALL_LOST,
  input  logic [BLOCK_COUNT-1:0] BLOCK_STATE,
  output logic                   START_UPDATE,
  output logic                   GAME_RESET,
  output logic                   SERVE_RESET,
  output logic [2:0]             PHASE,
  output logic [2:0]             LIVES,
  output logic [2:0]             LEVEL,
  output logic [7:0]             FRAME_COUNT,
  output logic [3:0]             OVERRUN_COUNT
);

  localparam int unsigned MAX_DELAY = (LOST_DELAY_FRAMES > CLEAR_DELAY_FRAMES) ?
                                      LOST_DELAY_FRAMES : CLEAR_DELAY_FRAMES;
  localparam int unsigned DW = (MAX_DELAY == 0) ? 1 : $clog2(MAX_DELAY + 1);
  localparam logic [DW-1:0] LOST_LOAD  = DW'(LOST_DELAY_FRAMES);
  localparam logic [DW-1:0] CLEAR_LOAD = DW'(CLEAR_DELAY_FRAMES);
  localparam logic [2:0]    LIVES_LOAD = 3'(INITIAL_LIVES);
  localparam logic [2:0]    LEVEL_TOP  = 3'(MAX_LEVEL);

  phaseE          phaseR, nextPhaseS;
  logic [DW-1:0]  delayR;
  logic [2:0]     livesR, levelR;
  logic [7:0]     frameCountR;
  logic [3:0]     overrunR;
  logic           startUpdateR, gameResetR, serveResetR;
  logic           releaseEdgeS, pauseEdgeS, allClearS, delayDoneS;
  logic           newGameS, lifeLostS, levelUpS, clearStatsS;
  logic           gameResetS, serveResetS, startUpdateS, overrunS, updateEligibleS;

  btn_edge_detect uRelease (.CLK(CLK), .RST_N(RST_N), .BTN(BTN_RELEASE), .EDGE(releaseEdgeS));
  btn_edge_detect uPause   (.CLK(CLK), .RST_N(RST_N), .BTN(BTN_PAUSE),   .EDGE(pauseEdgeS));

  assign allClearS  = ~|BLOCK_STATE;
  // A delay of N frames ends on the Nth FRAME_START; zero ends on the next one
  assign delayDoneS = FRAME_START && (delayR <= DW'(1));

  // Phase state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phaseR <= PH_ATTRACT;
    end else begin
      phaseR <= nextPhaseS;
    end
  end

  // Next-phase decode with the side effects each transition carries
  always_comb begin
    nextPhaseS  = phaseR;
    newGameS    = 1'b0;
    lifeLostS   = 1'b0;
    levelUpS    = 1'b0;
    clearStatsS = 1'b0;
    gameResetS  = 1'b0;
    serveResetS = 1'b0;
    case (phaseR)
      PH_ATTRACT: begin
        if (releaseEdgeS) begin
          nextPhaseS = PH_SERVE;
          newGameS   = 1'b1;
          gameResetS = 1'b1;
        end else begin
          nextPhaseS = PH_ATTRACT;
        end
      end
      PH_SERVE: begin
        if (releaseEdgeS) begin
          nextPhaseS = PH_PLAY;
        end else begin
          nextPhaseS = PH_SERVE;
        end
      end
      PH_PLAY: begin
        // Clearing the wall outranks losing the ball; both outrank pause
        if (allClearS) begin
          nextPhaseS = PH_LEVEL_CLEAR;
        end else if (BALL_LOST) begin
          nextPhaseS = PH_LIFE_LOST;
          lifeLostS  = 1'b1;
        end else if (pauseEdgeS) begin
          nextPhaseS = PH_PAUSED;
        end else begin
          nextPhaseS = PH_PLAY;
        end
      end
      PH_PAUSED: begin
        if (pauseEdgeS) begin
          nextPhaseS = PH_PLAY;
        end else begin
          nextPhaseS = PH_PAUSED;
        end
      end
      PH_LIFE_LOST: begin
        if (delayDoneS && (livesR == 3'd0)) begin
          nextPhaseS = PH_GAME_OVER;
        end else if (delayDoneS) begin
          nextPhaseS  = PH_SERVE;
          serveResetS = 1'b1;
        end else begin
          nextPhaseS = PH_LIFE_LOST;
        end
      end
      PH_LEVEL_CLEAR: begin
        if (delayDoneS && (levelR == LEVEL_TOP)) begin
          nextPhaseS = PH_GAME_OVER;
        end else if (delayDoneS) begin
          nextPhaseS = PH_SERVE;
          levelUpS   = 1'b1;
          gameResetS = 1'b1;
        end else begin
          nextPhaseS = PH_LEVEL_CLEAR;
        end
      end
      PH_GAME_OVER: begin
        if (releaseEdgeS) begin
          nextPhaseS  = PH_ATTRACT;
          clearStatsS = 1'b1;
        end else begin
          nextPhaseS = PH_GAME_OVER;
        end
      end
      default: begin
        nextPhaseS = PH_ATTRACT;
      end
    endcase
  end

  // Update gating: only in rally phases, and not on a frame that leaves them
  always_comb begin
    updateEligibleS = FRAME_START && isUpdatePhase(phaseR) && isUpdatePhase(nextPhaseS);
    startUpdateS    = updateEligibleS && !UPDATE_BUSY;
    overrunS        = updateEligibleS && UPDATE_BUSY;
  end

  // Registered one-cycle pulses toward the game logic
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      startUpdateR <= 1'b0;
      gameResetR   <= 1'b0;
      serveResetR  <= 1'b0;
    end else begin
      startUpdateR <= startUpdateS;
      gameResetR   <= gameResetS;
      serveResetR  <= serveResetS;
    end
  end

  // Lives and level bookkeeping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      livesR <= 3'd0;
      levelR <= 3'd0;
    end else if (newGameS) begin
      livesR <= LIVES_LOAD;
      levelR <= 3'd0;
    end else if (clearStatsS) begin
      livesR <= 3'd0;
      levelR <= 3'd0;
    end else if (lifeLostS && (livesR != 3'd0)) begin
      livesR <= livesR - 3'd1;
    end else if (levelUpS) begin
      levelR <= levelR + 3'd1;
    end else begin
      livesR <= livesR;
      levelR <= levelR;
    end
  end

  // Phase delay counter: loads on entry to a timed phase, counts frames down
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      delayR <= '0;
    end else if ((phaseR == PH_PLAY) && (nextPhaseS == PH_LIFE_LOST)) begin
      delayR <= LOST_LOAD;
    end else if ((phaseR == PH_PLAY) && (nextPhaseS == PH_LEVEL_CLEAR)) begin
      delayR <= CLEAR_LOAD;
    end else if (((phaseR == PH_LIFE_LOST) || (phaseR == PH_LEVEL_CLEAR)) &&
                 FRAME_START && (delayR != '0)) begin
      delayR <= delayR - DW'(1);
    end else begin
      delayR <= delayR;
    end
  end

  // Free-running frame counter and saturating overrun counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frameCountR <= 8'd0;
      overrunR    <= 4'd0;
    end else begin
      frameCountR <= FRAME_START ? (frameCountR + 8'd1) : frameCountR;
      overrunR    <= (overrunS && (overrunR != 4'd15)) ? (overrunR + 4'd1) : overrunR;
    end
  end

  assign START_UPDATE  = startUpdateR;
  assign GAME_RESET    = gameResetR;
  assign SERVE_RESET   = serveResetR;
  assign PHASE         = phaseR;
  assign LIVES         = livesR;
  assign LEVEL         = levelR;
  assign FRAME_COUNT   = frameCountR;
  assign OVERRUN_COUNT = overrunR;

endmodule
